bus_arbiter: RTL and testbench

- Arbitration and split-transaction scheduler for the two-initiator / three-target serial bus.
- Grants bus ownership to init1 or init2 with round-robin fairness.
- Suspends an initiator when the split target answers with split-ack, and lets the other initiator use the bus meanwhile.
- Hands the bus back to the split target and the suspended initiator when the split target requests it; a watchdog abandons stale splits.

---
 rtl/bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_bus_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for two initiators sharing a serial bus with one split-capable target.
// Grants are registered one cycle behind the FSM state, so every handover has an idle turnaround.
module bus_arbiter #(
  parameter int SPLIT_TIMEOUT = 64,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init1_req,
  input  logic init2_req,
  input  logic split_ack,
  input  logic split_req,
  output logic init1_grant,
  output logic init2_grant,
  output logic split_grant,
  output logic sel_init,
  output logic split_pending,
  output logic split_owner,
  output logic split_timeout
);

  typedef enum logic [1:0] {IDLE, OWN1, OWN2, RESUME} state_t;

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(SPLIT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic             rr, rr_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             pending_nxt, owner_nxt, timeout_nxt;
  logic             grant1_nxt, grant2_nxt, sgrant_nxt, sel_nxt;
  logic             req1_ok, req2_ok, expire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr            <= 1'b0;
      count         <= '0;
      split_pending <= 1'b0;
      split_owner   <= 1'b0;
      split_timeout <= 1'b0;
      init1_grant   <= 1'b0;
      init2_grant   <= 1'b0;
      split_grant   <= 1'b0;
      sel_init      <= 1'b0;
    end else begin
      state         <= state_nxt;
      rr            <= rr_nxt;
      count         <= count_nxt;
      split_pending <= pending_nxt;
      split_owner   <= owner_nxt;
      split_timeout <= timeout_nxt;
      init1_grant   <= grant1_nxt;
      init2_grant   <= grant2_nxt;
      split_grant   <= sgrant_nxt;
      sel_init      <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr;
    count_nxt   = count;
    pending_nxt = split_pending;
    owner_nxt   = split_owner;
    timeout_nxt = 1'b0;
    grant1_nxt  = 1'b0;
    grant2_nxt  = 1'b0;
    sgrant_nxt  = 1'b0;
    sel_nxt     = sel_init;

    // The suspended initiator stays off the bus until its split resolves.
    req1_ok = init1_req && !(split_pending && !split_owner);
    req2_ok = init2_req && !(split_pending && split_owner);
    expire  = split_pending && (state != RESUME) && (count == LAST);

    if (split_pending && (state != RESUME)) begin
      if (expire) begin
        pending_nxt = 1'b0;
        timeout_nxt = 1'b1;
        count_nxt   = '0;
      end else if (count != CNT_MAX) begin
        count_nxt = count + CNT_W'(1);
      end
    end

    case (state)
      IDLE: begin
        if (split_pending && split_req && !expire)
          state_nxt = RESUME;
        else if (req1_ok && req2_ok)
          state_nxt = rr ? OWN2 : OWN1;
        else if (req1_ok)
          state_nxt = OWN1;
        else if (req2_ok)
          state_nxt = OWN2;
      end
      OWN1: begin
        grant1_nxt = 1'b1;
        sel_nxt    = 1'b0;
        if (!init1_req) begin
          state_nxt = IDLE;
          rr_nxt    = 1'b1;
        end else if (split_ack && !split_pending) begin
          state_nxt   = IDLE;
          pending_nxt = 1'b1;
          owner_nxt   = 1'b0;
          count_nxt   = '0;
          rr_nxt      = 1'b1;
        end
      end
      OWN2: begin
        grant2_nxt = 1'b1;
        sel_nxt    = 1'b1;
        if (!init2_req) begin
          state_nxt = IDLE;
          rr_nxt    = 1'b0;
        end else if (split_ack && !split_pending) begin
          state_nxt   = IDLE;
          pending_nxt = 1'b1;
          owner_nxt   = 1'b1;
          count_nxt   = '0;
          rr_nxt      = 1'b0;
        end
      end
      RESUME: begin
        // Read data flows back through the suspended initiator's path.
        sgrant_nxt = 1'b1;
        grant1_nxt = !split_owner;
        grant2_nxt = split_owner;
        sel_nxt    = split_owner;
        if (!split_req) begin
          state_nxt   = IDLE;
          pending_nxt = 1'b0;
          count_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, hand sequences, and random traffic
// compared against an ownership-level reference model.
module tb_bus_arbiter;

  localparam int TO = 8;

  logic clk;
  logic rst_n, init1_req, init2_req, split_ack, split_req;
  logic init1_grant, init2_grant, split_grant, sel_init;
  logic split_pending, split_owner, split_timeout;

  int checks   = 0;
  int failures = 0;

  bus_arbiter #(.SPLIT_TIMEOUT(TO), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .init1_req     (init1_req),
    .init2_req     (init2_req),
    .split_ack     (split_ack),
    .split_req     (split_req),
    .init1_grant   (init1_grant),
    .init2_grant   (init2_grant),
    .split_grant   (split_grant),
    .sel_init      (sel_init),
    .split_pending (split_pending),
    .split_owner   (split_owner),
    .split_timeout (split_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // split_ack while a split is already outstanding is a protocol violation.
  always @(posedge clk) begin
    assert (!(rst_n && split_ack && split_pending))
    else begin
      failures++;
      $display("[TB] FAIL split_ack_while_pending: got ack=1 pending=1, required no ack while pending");
    end
  end

  // Reference model: owner 0 = nobody, 1 = init1, 2 = init2, 3 = split target resuming.
  int       m_owner   = 0;
  bit       m_pending = 1'b0;
  int       m_victim  = 1;
  int       m_age     = 0;
  int       m_pref    = 1;
  logic [6:0] m_out   = '0;

  task automatic modelEdge(input bit rst, input bit r1, input bit r2, input bit ack, input bit sreq);
    bit g1, g2, sg, sel, to, was_pending, ok1, ok2, owner_req;
    int nxt;
    if (!rst) begin
      m_owner = 0; m_pending = 1'b0; m_victim = 1; m_age = 0; m_pref = 1; m_out = '0;
    end else begin
      g1  = (m_owner == 1) || (m_owner == 3 && m_victim == 1);
      g2  = (m_owner == 2) || (m_owner == 3 && m_victim == 2);
      sg  = (m_owner == 3);
      sel = m_out[3];
      if (m_owner == 1) sel = 1'b0;
      else if (m_owner == 2) sel = 1'b1;
      else if (m_owner == 3) sel = (m_victim == 2);
      was_pending = m_pending;
      ok1 = r1 && !(m_pending && m_victim == 1);
      ok2 = r2 && !(m_pending && m_victim == 2);
      to  = m_pending && m_owner != 3 && m_age == TO - 1;
      if (m_pending && m_owner != 3) begin
        if (to) begin m_pending = 1'b0; m_age = 0; end
        else m_age++;
      end
      nxt = m_owner;
      if (m_owner == 0) begin
        if (was_pending && sreq && !to) nxt = 3;
        else if (ok1 && ok2) nxt = m_pref;
        else if (ok1) nxt = 1;
        else if (ok2) nxt = 2;
      end else if (m_owner == 3) begin
        if (!sreq) begin nxt = 0; m_pending = 1'b0; m_age = 0; end
      end else begin
        owner_req = (m_owner == 1) ? r1 : r2;
        if (!owner_req) begin
          nxt = 0; m_pref = 3 - m_owner;
        end else if (ack && !was_pending) begin
          nxt = 0; m_pending = 1'b1; m_victim = m_owner; m_age = 0; m_pref = 3 - m_owner;
        end
      end
      m_owner = nxt;
      m_out = {g1, g2, sg, sel, m_pending, (m_victim == 2), to};
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit r1, input bit r2, input bit ack, input bit sreq);
    @(negedge clk);
    rst_n = rst; init1_req = r1; init2_req = r2; split_ack = ack; split_req = sreq;
    @(posedge clk);
    modelEdge(rst, r1, r2, ack, sreq);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {init1_grant, init2_grant, split_grant, sel_init, split_pending, split_owner, split_timeout};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got g1,g2,sg,sel,pend,own,to=%b required %b", name, act, exp);
    end
  endtask

  typedef struct {
    bit rst, r1, r2, ack, sreq;
    logic [6:0] exp;   // {g1, g2, sg, sel, pend, own, to}
  } vec_t;

  vec_t vecs[17];
  bit   rr1, rr2, rrst, rack, rsreq;
  logic [6:0] e;

  initial begin
    rst_n = 1'b0; init1_req = 1'b0; init2_req = 1'b0; split_ack = 1'b0; split_req = 1'b0;

    vecs[0]  = '{0, 0, 0, 0, 0, 7'b0000000};  // reset
    vecs[1]  = '{1, 1, 1, 0, 0, 7'b0000000};  // contention sampled
    vecs[2]  = '{1, 1, 1, 0, 0, 7'b1000000};  // init1 wins first
    vecs[3]  = '{1, 0, 1, 0, 0, 7'b1000000};  // init1 releases
    vecs[4]  = '{1, 0, 1, 0, 0, 7'b0000000};  // turnaround
    vecs[5]  = '{1, 0, 1, 0, 0, 7'b0101000};  // init2 owns
    vecs[6]  = '{1, 0, 1, 1, 0, 7'b0101110};  // split_ack from target
    vecs[7]  = '{1, 1, 1, 0, 0, 7'b0001110};  // init2 masked, init1 picked
    vecs[8]  = '{1, 1, 1, 0, 1, 7'b1000110};  // split_req waits for owner
    vecs[9]  = '{1, 0, 1, 0, 1, 7'b1000110};  // init1 releases
    vecs[10] = '{1, 0, 1, 0, 1, 7'b0000110};  // IDLE -> resume ahead of init2
    vecs[11] = '{1, 0, 1, 0, 1, 7'b0111110};  // resume grants
    vecs[12] = '{1, 0, 1, 0, 0, 7'b0111010};  // split_req falls
    vecs[13] = '{1, 0, 1, 0, 0, 7'b0001010};  // turnaround
    vecs[14] = '{1, 0, 0, 0, 0, 7'b0101010};  // init2 owns then releases
    vecs[15] = '{1, 1, 1, 0, 0, 7'b0001010};  // contention, rr back to init1
    vecs[16] = '{1, 1, 1, 0, 0, 7'b1000010};  // init1 wins

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].r1, vecs[i].r2, vecs[i].ack, vecs[i].sreq);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Watchdog: split with no split_req expires TO edges after the ack edge.
    applyStimulus(1, 1, 0, 1, 0);
    checkOutput("split_own1", 7'b1000100);
    for (int k = 1; k <= TO; k++) begin
      applyStimulus(1, 0, 0, 0, (k == TO));
      e = {4'b0000, (k < TO), 1'b0, (k == TO)};
      checkOutput($sformatf("timeout_edge%0d", k), e);
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 0, 0, 0, 1);
      checkOutput("stale_split_req_ignored", 7'b0000000);
    end

    // Reset in the middle of a resume.
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("own2_before_split", 7'b0101000);
    applyStimulus(1, 0, 1, 1, 0);
    applyStimulus(1, 0, 1, 0, 1);
    applyStimulus(1, 0, 1, 0, 1);
    checkOutput("resume_owner2", 7'b0111110);
    applyStimulus(0, 1, 1, 0, 1);
    checkOutput("reset_mid_resume", 7'b0000000);
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("after_reset_idle", 7'b0000000);
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("after_reset_init1", 7'b1000000);

    // Random traffic against the reference model.
    rr1 = 1'b0; rr2 = 1'b0; rsreq = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rand_reset", m_out);
    for (int i = 0; i < 3000; i++) begin
      rrst = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0) rr1 = ~rr1;
      if ($urandom_range(0, 3) == 0) rr2 = ~rr2;
      if ($urandom_range(0, 4) == 0) rsreq = ~rsreq;
      rack = !m_pending && ($urandom_range(0, 5) == 0);
      applyStimulus(rrst, rr1, rr2, rack, rsreq);
      checkOutput("random", m_out);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
